d8_mem_access_ctrl: RTL and testbench
=====================================

# d8_mem_access_ctrl

Parametrised data-memory access sequencer for the d8 core, successor to the single-opcode store-enable decode. It decodes load and store opcodes at configurable opcode, address and data widths and runs a registered request/acknowledge transaction against the data memory port. While a transaction is open it stalls the execute stage, and it reports completion, load data or a timeout error. It sits between the d8 execute stage and the data memory bus.

## Interface
- OP_W, 8: opcode width.
- ADDR_W, 8: memory address width.
- DATA_W, 8: memory data width.
- OP_LOAD, 8'h07: load opcode, OP_W bits.
- OP_STORE, 8'h08: store opcode, OP_W bits.
- TIMEOUT, 16: maximum number of cycles in ACCESS without an ack; must be ≥ 1.

- clk  in  1  single core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue  in  1  execute stage presents `op`/`addr`/`wdata` this cycle.
- op  in  OP_W  opcode.
- addr  in  ADDR_W  effective address.
- wdata  in  DATA_W  store data.
- busy  out  1  transaction open (state ≠ IDLE); execute stage stalls.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse, coincident with `done`.
- rdata  out  DATA_W  load result, valid from `done` until the next load completes.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; stable while `mem_req` is asserted.
- mem_addr  out  ADDR_W  request address; stable while `mem_req` is asserted.
- mem_wdata  out  DATA_W  write data; stable while `mem_req` is asserted.
- mem_rdata  in  DATA_W  read data, sampled on the ack cycle.
- mem_ack  in  1  memory accepts the request (write) or returns data (read).

## Operation
- Reset values: state IDLE, all outputs 0, timeout counter 0.
- Decode: `is_load = (op == OP_LOAD)`, `is_store = (op == OP_STORE)`. Any other opcode is ignored: no state change, no pulse.
- IDLE: when `issue & (is_load | is_store)`, register `addr`, `wdata` and `mem_we = is_store`, clear the counter, and go to ACCESS.
- ACCESS: `mem_req = 1`.
  - On `mem_ack`: for a load, capture `mem_rdata` into `rdata`; go to DONE.
  - Otherwise, if counter == TIMEOUT-1, go to ERR; else increment the counter.
- DONE: `done = 1` for one cycle; `mem_req = 0`; return to IDLE.
- ERR: `done = 1` and `err = 1` for one cycle; `rdata` is unchanged; return to IDLE.
- `issue` while `busy` is ignored. The execute stage holds its instruction because `busy` is set.
- Counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Stores leave `rdata` unchanged.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Issue accepted at edge 0 → `mem_req` and `busy` high in cycle 1.
- Ack in cycle k (k ≥ 1) → `done` in cycle k+1, `mem_req` low in cycle k+1. Minimum issue-to-done latency: 2 cycles.
- No ack → `mem_req` asserted for exactly TIMEOUT cycles, then `err`/`done` in the following cycle.
- Ack in the same cycle the counter reaches TIMEOUT-1: the ack wins, giving normal completion with no `err`.
- `mem_ack` while not in ACCESS is ignored.
- `busy` falls in the cycle after `done`/`err`. A new issue can be accepted in that cycle, giving back-to-back transactions with 1 idle cycle.
- `rst` mid-transaction: every output and the state are 0/IDLE on the next edge. An outstanding memory request is abandoned; the memory side must tolerate `mem_req` dropping.

## Structure
- Shared package `d8_pkg`: the opcode constants (OP_LOAD 8'h07, OP_STORE 8'h08), the FSM state encoding (IDLE, ACCESS, DONE, ERR, 2 bits) and the default widths.
- One sub-module: `d8_mem_op_decode`, a combinational decoder (op → is_load, is_store), parametrised by OP_W/OP_LOAD/OP_STORE. The execute stage reuses it.
- The top level holds the FSM, address/data/we registers, the timeout counter and the `rdata` register.

## Test plan
- Store: issue op=08, addr=0x3C, wdata=0xA5; ack in cycle 1 → `mem_req`/`mem_we` high in cycle 1 with mem_addr=0x3C and mem_wdata=0xA5; `done` in cycle 2; `rdata` unchanged; `err` = 0.
- Load with waits: issue op=07, addr=0x10; ack in cycle 4 with mem_rdata=0x5E → `mem_req` high in cycles 1–4 with `mem_we` = 0; `done` in cycle 5; `rdata` = 0x5E from cycle 5.
- Timeout: TIMEOUT=4, load with no ack → `mem_req` high in cycles 1–4; `done` and `err` in cycle 5; `rdata` keeps its old value. With ack in cycle 4 instead → normal `done`, `err` = 0.
- Ignored inputs: issue op=0x03 → no `busy`, no `mem_req`. Issue a store while a load is busy → only the load is performed. Spurious `mem_ack` in IDLE → no effect.
- Back-to-back: load then store issued in the cycle after `done` → two complete transactions with 1 idle cycle between them.
- Reset in cycle 2 of a waiting load → cycle 3: `mem_req`, `busy`, `done`, `err` and `rdata` all 0; the next issue is accepted normally.

Source files
------------

// File: rtl/d8_pkg.sv
// Shared d8 core definitions: default widths, memory opcodes and the
// memory-access sequencer state encoding.
package d8_pkg;

   localparam int D8_OP_W   = 8;
   localparam int D8_ADDR_W = 8;
   localparam int D8_DATA_W = 8;

   localparam logic [7:0] D8_OP_LOAD  = 8'h07;
   localparam logic [7:0] D8_OP_STORE = 8'h08;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

endpackage : d8_pkg

// File: rtl/d8_mem_op_decode.sv
// Combinational load/store opcode decoder, shared with the execute stage.
module d8_mem_op_decode
   import d8_pkg::*;
#(
   parameter int              OP_W     = D8_OP_W,
   parameter logic [OP_W-1:0] OP_LOAD  = OP_W'(D8_OP_LOAD),
   parameter logic [OP_W-1:0] OP_STORE = OP_W'(D8_OP_STORE)
) (
   input  logic [OP_W-1:0] op,
   output logic            is_load,
   output logic            is_store
);

   assign is_load  = (op == OP_LOAD);
   assign is_store = (op == OP_STORE);

endmodule : d8_mem_op_decode

// File: rtl/d8_mem_access_ctrl.sv
// Data-memory access sequencer: decodes load/store, runs a req/ack
// transaction with timeout, stalls execute while a transaction is open.
module d8_mem_access_ctrl
   import d8_pkg::*;
#(
   parameter int              OP_W     = D8_OP_W,
   parameter int              ADDR_W   = D8_ADDR_W,
   parameter int              DATA_W   = D8_DATA_W,
   parameter logic [OP_W-1:0] OP_LOAD  = OP_W'(D8_OP_LOAD),
   parameter logic [OP_W-1:0] OP_STORE = OP_W'(D8_OP_STORE),
   parameter int              TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [OP_W-1:0]   op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_load, is_store;
   logic               accept;
   logic               capture;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               we_q;
   logic [DATA_W-1:0]  rdata_q;

   d8_mem_op_decode #(
      .OP_W     (OP_W),
      .OP_LOAD  (OP_LOAD),
      .OP_STORE (OP_STORE)
   ) u_decode (
      .op       (op),
      .is_load  (is_load),
      .is_store (is_store)
   );

   // NOTE: every signal driven here gets its default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue && (is_load || is_store)) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // The ack is tested first so that it wins on the final wait cycle.
            if (mem_ack) begin
               capture = !we_q;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERR;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The request fields are loaded only on accept, which keeps them stable
   // for the whole time mem_req is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= is_store;
         end
         if (capture) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Outputs decode registered state only; nothing reaches them from inputs.
   assign busy      = (state_q != IDLE);
   assign mem_req   = (state_q == ACCESS);
   assign done      = (state_q == DONE) || (state_q == ERR);
   assign err       = (state_q == ERR);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule : d8_mem_access_ctrl

// File: tb/tb_d8_mem_access_ctrl.sv
// Directed bench for d8_mem_access_ctrl with TIMEOUT=4; cycle n is the
// window after edge n-1, inputs driven and outputs sampled 1 time unit in.
module tb_d8_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue;
   logic [7:0] op;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] rdata;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;

   int n_vec  = 0;
   int n_miss = 0;
   logic [7:0] exp_rdata;

   always #5 clk = ~clk;

   d8_mem_access_ctrl #(
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue),
      .op        (op),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] o, input logic [7:0] a, input logic [7:0] d);
      issue = 1'b1;
      op    = o;
      addr  = a;
      wdata = d;
      tick();
      issue = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_vec++;
      if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
         n_miss++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_req, mem_we});
      end
      n_vec++;
      if ({rdata, mem_addr, mem_wdata} !== 24'h0) begin
         n_miss++;
         $display("FAIL reset_data: got %h want 000000", {rdata, mem_addr, mem_wdata});
      end
   endtask

   task automatic test_store();
      start(8'h08, 8'h3C, 8'hA5);
      n_vec++;
      if ({busy, mem_req, mem_we, done, mem_addr, mem_wdata} !== {4'b1110, 8'h3C, 8'hA5}) begin
         n_miss++;
         $display("FAIL store_req: got %b %h %h want 1110 3c a5",
                  {busy, mem_req, mem_we, done}, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_vec++;
      if ({done, err, mem_req, rdata} !== {3'b100, exp_rdata}) begin
         n_miss++;
         $display("FAIL store_done: got %b %h want 100 %h", {done, err, mem_req}, rdata, exp_rdata);
      end
      tick();
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_miss++;
         $display("FAIL store_idle: got %b want 00", {busy, done});
      end
   endtask

   task automatic test_load_wait();
      start(8'h07, 8'h10, 8'hFF);
      for (int c = 1; c <= 4; c++) begin
         n_vec++;
         if ({mem_req, mem_we, done, mem_addr} !== {3'b100, 8'h10}) begin
            n_miss++;
            $display("FAIL load_wait_c%0d: got %b %h want 100 10", c, {mem_req, mem_we, done}, mem_addr);
         end
         if (c == 4) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'h5E;
         end
         tick();
      end
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      exp_rdata = 8'h5E;
      n_vec++;
      if ({done, err, mem_req, rdata} !== {3'b100, exp_rdata}) begin
         n_miss++;
         $display("FAIL load_done: got %b %h want 100 %h", {done, err, mem_req}, rdata, exp_rdata);
      end
      tick();
      n_vec++;
      if ({busy, rdata} !== {1'b0, exp_rdata}) begin
         n_miss++;
         $display("FAIL load_hold: got %b %h want 0 %h", busy, rdata, exp_rdata);
      end
   endtask

   task automatic test_timeout();
      start(8'h07, 8'h20, 8'h00);
      mem_rdata = 8'hEE;
      for (int c = 1; c <= 4; c++) begin
         n_vec++;
         if ({mem_req, done, err} !== 3'b100) begin
            n_miss++;
            $display("FAIL timeout_wait_c%0d: got %b want 100", c, {mem_req, done, err});
         end
         tick();
      end
      n_vec++;
      if ({done, err, mem_req, rdata} !== {3'b110, exp_rdata}) begin
         n_miss++;
         $display("FAIL timeout_err: got %b %h want 110 %h", {done, err, mem_req}, rdata, exp_rdata);
      end
      tick();
      n_vec++;
      if ({busy, done, err} !== 3'b000) begin
         n_miss++;
         $display("FAIL timeout_idle: got %b want 000", {busy, done, err});
      end
   endtask

   task automatic test_ack_at_limit();
      start(8'h07, 8'h21, 8'h00);
      tick();
      tick();
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 8'hC3;
      n_vec++;
      if ({mem_req, done} !== 2'b10) begin
         n_miss++;
         $display("FAIL limit_c4: got %b want 10", {mem_req, done});
      end
      tick();
      mem_ack   = 1'b0;
      exp_rdata = 8'hC3;
      n_vec++;
      if ({done, err, rdata} !== {2'b10, exp_rdata}) begin
         n_miss++;
         $display("FAIL limit_done: got %b %h want 10 %h", {done, err}, rdata, exp_rdata);
      end
      tick();
   endtask

   task automatic test_ignored();
      start(8'h03, 8'h33, 8'h44);
      n_vec++;
      if ({busy, mem_req, done} !== 3'b000) begin
         n_miss++;
         $display("FAIL bad_opcode: got %b want 000", {busy, mem_req, done});
      end
      mem_ack   = 1'b1;
      mem_rdata = 8'h77;
      tick();
      mem_ack = 1'b0;
      n_vec++;
      if ({busy, done, err, rdata} !== {3'b000, exp_rdata}) begin
         n_miss++;
         $display("FAIL idle_ack: got %b %h want 000 %h", {busy, done, err}, rdata, exp_rdata);
      end
      start(8'h07, 8'h44, 8'h00);
      start(8'h08, 8'h99, 8'h11);
      n_vec++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h44}) begin
         n_miss++;
         $display("FAIL busy_issue: got %b %h want 10 44", {mem_req, mem_we}, mem_addr);
      end
      mem_ack   = 1'b1;
      mem_rdata = 8'h9A;
      tick();
      mem_ack   = 1'b0;
      exp_rdata = 8'h9A;
      n_vec++;
      if ({done, rdata} !== {1'b1, exp_rdata}) begin
         n_miss++;
         $display("FAIL busy_done: got %b %h want 1 %h", done, rdata, exp_rdata);
      end
      tick();
      tick();
      n_vec++;
      if ({busy, mem_req} !== 2'b00) begin
         n_miss++;
         $display("FAIL busy_dropped: got %b want 00", {busy, mem_req});
      end
   endtask

   task automatic test_back_to_back();
      start(8'h07, 8'h50, 8'h00);
      mem_ack   = 1'b1;
      mem_rdata = 8'h6B;
      tick();
      mem_ack   = 1'b0;
      exp_rdata = 8'h6B;
      n_vec++;
      if ({done, rdata} !== {1'b1, exp_rdata}) begin
         n_miss++;
         $display("FAIL b2b_load: got %b %h want 1 %h", done, rdata, exp_rdata);
      end
      tick();
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_miss++;
         $display("FAIL b2b_gap: got %b want 00", {busy, done});
      end
      start(8'h08, 8'h51, 8'h3D);
      n_vec++;
      if ({busy, mem_req, mem_we, mem_addr, mem_wdata} !== {3'b111, 8'h51, 8'h3D}) begin
         n_miss++;
         $display("FAIL b2b_store_req: got %b %h %h want 111 51 3d",
                  {busy, mem_req, mem_we}, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_vec++;
      if ({done, err, rdata} !== {2'b10, exp_rdata}) begin
         n_miss++;
         $display("FAIL b2b_store_done: got %b %h want 10 %h", {done, err}, rdata, exp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      start(8'h07, 8'h60, 8'h00);
      tick();
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      exp_rdata = 8'h00;
      n_vec++;
      if ({mem_req, busy, done, err, rdata} !== {4'b0000, exp_rdata}) begin
         n_miss++;
         $display("FAIL mid_reset: got %b %h want 0000 %h", {mem_req, busy, done, err}, rdata, exp_rdata);
      end
      start(8'h08, 8'h12, 8'h34);
      n_vec++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h12, 8'h34}) begin
         n_miss++;
         $display("FAIL post_reset_req: got %b %h %h want 11 12 34", {mem_req, mem_we}, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_vec++;
      if ({done, err} !== 2'b10) begin
         n_miss++;
         $display("FAIL post_reset_done: got %b want 10", {done, err});
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      issue     = 1'b0;
      op        = 8'h00;
      addr      = 8'h00;
      wdata     = 8'h00;
      mem_rdata = 8'h00;
      mem_ack   = 1'b0;
      exp_rdata = 8'h00;
      #1;
      test_reset();
      test_store();
      test_load_wait();
      test_timeout();
      test_ack_at_limit();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_d8_mem_access_ctrl
